// File: rtl/game_core_grid.sv
// NxN 2048 engine: one slide/merge move per handshake, one line compressed per cycle, LFSR tile spawn.
// Optional GAME_SCORE_EN adds a saturating merge score; without it score is tied to zero.
module game_core_grid #(
    parameter int          GRID_N    = 4,
    parameter int          EXP_W     = 4,
    parameter int          WIN_EXP   = 11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            new_game,
    input  logic                            move_valid,
    input  logic [1:0]                      move_dir,
    output logic                            move_ready,
    output logic                            move_done,
    output logic                            move_chg,
    output logic [GRID_N*GRID_N*EXP_W-1:0]  board,
    output logic                            win,
    output logic                            game_over,
    output logic [31:0]                     score
);

    localparam int NCELLS = GRID_N * GRID_N;
    localparam int CELL_W = $clog2(NCELLS);
    localparam int LINE_W = $clog2(GRID_N);
    localparam int CNT_W  = CELL_W + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SPAWN,
        ST_SHIFT,
        ST_CHECK,
        ST_IDLE
    } state_t;

    state_t                state;
    logic [EXP_W-1:0]      cells   [NCELLS];
    logic [EXP_W-1:0]      shifted [NCELLS];
    logic [EXP_W-1:0]      line_in  [GRID_N];
    logic [EXP_W-1:0]      line_out [GRID_N];
    logic                  line_chg;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [LINE_W-1:0]     line_idx;
    logic [1:0]            dir;
    logic                  changed;
    logic                  init_phase;
    logic                  init_more;
    logic                  spawn_first;
    logic                  ready_q;
    logic [CELL_W-1:0]     spawn_pos;
    logic [CELL_W-1:0]     start_idx;
    logic [CELL_W-1:0]     cur_pos;
    logic [CELL_W-1:0]     next_pos;
    logic [CNT_W-1:0]      spawn_cnt;
    logic                  cur_empty;
    logic [EXP_W-1:0]      spawn_val;
    logic                  any_win;
    logic                  any_empty;
    logic                  any_pair;
    logic                  go_now;
    logic [EXP_W-1:0]      merged;
    logic [EXP_W-1:0]      pend;
    logic                  have;
    int                    wr;
`ifdef GAME_SCORE_EN
    logic [32:0]           gain;
    logic [32:0]           score_sum;
    logic [31:0]           score_q;
`endif

    assign lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign move_ready = ready_q && !new_game;
    assign go_now     = !any_empty && !any_pair;

    always_comb begin
        for (int i = 0; i < NCELLS; i++) begin
            board[i*EXP_W +: EXP_W] = cells[i];
        end
    end

    // Gather the active line so index 0 is always the cell at the move's leading edge.
    always_comb begin
        for (int j = 0; j < GRID_N; j++) begin
            line_in[j] = '0;
        end
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                case (dir)
                    2'd0:    if (c == int'(line_idx)) line_in[r] = cells[r*GRID_N+c];
                    2'd1:    if (c == int'(line_idx)) line_in[GRID_N-1-r] = cells[r*GRID_N+c];
                    2'd2:    if (r == int'(line_idx)) line_in[c] = cells[r*GRID_N+c];
                    default: if (r == int'(line_idx)) line_in[GRID_N-1-c] = cells[r*GRID_N+c];
                endcase
            end
        end
    end

    always_comb begin
        for (int j = 0; j < GRID_N; j++) begin
            line_out[j] = '0;
        end
        wr     = 0;
        have   = 1'b0;
        pend   = '0;
        merged = '0;
`ifdef GAME_SCORE_EN
        gain   = '0;
`endif
        // pend holds the last unmerged tile; a merge consumes it so the result cannot merge again.
        for (int j = 0; j < GRID_N; j++) begin
            if (line_in[j] != '0) begin
                if (have && pend == line_in[j]) begin
                    merged = (line_in[j] == EXP_MAX) ? EXP_MAX : line_in[j] + 1'b1;
                    for (int k = 0; k < GRID_N; k++) begin
                        if (k == wr) line_out[k] = merged;
                    end
                    wr   = wr + 1;
                    have = 1'b0;
`ifdef GAME_SCORE_EN
                    gain = gain + (33'd1 << merged);
                    if (gain[32]) gain = {1'b0, 32'hFFFF_FFFF};
`endif
                end else begin
                    if (have) begin
                        for (int k = 0; k < GRID_N; k++) begin
                            if (k == wr) line_out[k] = pend;
                        end
                        wr = wr + 1;
                    end
                    pend = line_in[j];
                    have = 1'b1;
                end
            end
        end
        if (have) begin
            for (int k = 0; k < GRID_N; k++) begin
                if (k == wr) line_out[k] = pend;
            end
        end
    end

    always_comb begin
        line_chg = 1'b0;
        for (int j = 0; j < GRID_N; j++) begin
            if (line_out[j] != line_in[j]) line_chg = 1'b1;
        end
        shifted = cells;
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                case (dir)
                    2'd0:    if (c == int'(line_idx)) shifted[r*GRID_N+c] = line_out[r];
                    2'd1:    if (c == int'(line_idx)) shifted[r*GRID_N+c] = line_out[GRID_N-1-r];
                    2'd2:    if (r == int'(line_idx)) shifted[r*GRID_N+c] = line_out[c];
                    default: if (r == int'(line_idx)) shifted[r*GRID_N+c] = line_out[GRID_N-1-c];
                endcase
            end
        end
    end

    // The scan start comes from the LFSR on the first spawn cycle, later cycles walk forward.
    always_comb begin
        start_idx = lfsr[CELL_W-1:0];
        if (int'(lfsr[CELL_W-1:0]) >= NCELLS) start_idx = lfsr[CELL_W-1:0] - CELL_W'(NCELLS);
        cur_pos   = spawn_first ? start_idx : spawn_pos;
        next_pos  = (int'(cur_pos) == NCELLS - 1) ? '0 : cur_pos + 1'b1;
        cur_empty = (cells[cur_pos] == '0);
        spawn_val = (lfsr[15:12] == 4'd0) ? EXP_W'(2) : EXP_W'(1);
    end

    always_comb begin
        any_win   = 1'b0;
        any_empty = 1'b0;
        any_pair  = 1'b0;
        for (int i = 0; i < NCELLS; i++) begin
            if (int'(cells[i]) >= WIN_EXP) any_win = 1'b1;
            if (cells[i] == '0) any_empty = 1'b1;
        end
        for (int r = 0; r < GRID_N; r++) begin
            for (int c = 0; c < GRID_N - 1; c++) begin
                if (cells[r*GRID_N+c] == cells[r*GRID_N+c+1]) any_pair = 1'b1;
            end
        end
        for (int r = 0; r < GRID_N - 1; r++) begin
            for (int c = 0; c < GRID_N; c++) begin
                if (cells[r*GRID_N+c] == cells[(r+1)*GRID_N+c]) any_pair = 1'b1;
            end
        end
    end

`ifdef GAME_SCORE_EN
    assign score_sum = {1'b0, score_q} + gain;
    assign score     = score_q;
`else
    assign score     = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_INIT;
            for (int i = 0; i < NCELLS; i++) cells[i] <= '0;
            lfsr        <= LFSR_SEED;
            line_idx    <= '0;
            dir         <= '0;
            changed     <= 1'b0;
            init_phase  <= 1'b0;
            init_more   <= 1'b0;
            spawn_first <= 1'b0;
            spawn_pos   <= '0;
            spawn_cnt   <= '0;
            ready_q     <= 1'b0;
            move_done   <= 1'b0;
            move_chg    <= 1'b0;
            win         <= 1'b0;
            game_over   <= 1'b0;
`ifdef GAME_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            lfsr      <= lfsr_next;
            move_done <= 1'b0;
            move_chg  <= 1'b0;
            if (new_game) begin
                state     <= ST_INIT;
                for (int i = 0; i < NCELLS; i++) cells[i] <= '0;
                lfsr      <= LFSR_SEED;
                ready_q   <= 1'b0;
                win       <= 1'b0;
                game_over <= 1'b0;
`ifdef GAME_SCORE_EN
                score_q   <= '0;
`endif
            end else begin
                case (state)
                    ST_INIT: begin
                        state       <= ST_SPAWN;
                        init_phase  <= 1'b1;
                        init_more   <= 1'b1;
                        spawn_first <= 1'b1;
                        spawn_cnt   <= '0;
                    end
                    ST_IDLE: begin
                        if (move_valid && ready_q) begin
                            state    <= ST_SHIFT;
                            dir      <= move_dir;
                            line_idx <= '0;
                            changed  <= 1'b0;
                            ready_q  <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        for (int i = 0; i < NCELLS; i++) cells[i] <= shifted[i];
                        changed <= changed | line_chg;
`ifdef GAME_SCORE_EN
                        score_q <= score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
`endif
                        if (line_idx == LINE_W'(GRID_N - 1)) begin
                            if (changed || line_chg) begin
                                state       <= ST_SPAWN;
                                init_phase  <= 1'b0;
                                init_more   <= 1'b0;
                                spawn_first <= 1'b1;
                                spawn_cnt   <= '0;
                            end else begin
                                state     <= ST_CHECK;
                                move_done <= 1'b1;
                            end
                        end else begin
                            line_idx <= line_idx + 1'b1;
                        end
                    end
                    ST_SPAWN: begin
                        spawn_first <= 1'b0;
                        if (cur_empty) cells[cur_pos] <= spawn_val;
                        if (cur_empty || spawn_cnt == CNT_W'(NCELLS - 1)) begin
                            spawn_cnt <= '0;
                            if (init_more) begin
                                init_more   <= 1'b0;
                                spawn_first <= 1'b1;
                            end else begin
                                state     <= ST_CHECK;
                                move_done <= !init_phase;
                                move_chg  <= !init_phase;
                            end
                        end else begin
                            spawn_pos <= next_pos;
                            spawn_cnt <= spawn_cnt + 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        win       <= win | any_win;
                        game_over <= game_over | go_now;
                        ready_q   <= !(game_over || go_now);
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_INIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_core_grid.sv
// Bench for game_core_grid on a 3x3 board: reset vector table, then random play checked
// against a queue-based board model with its own LFSR-driven spawn prediction.
module tb_game_core_grid;

    localparam int N    = 3;
    localparam int EW   = 3;
    localparam int WE   = 4;
    localparam int NC   = N * N;
    localparam int CW   = $clog2(NC);
    localparam int MAXE = 7;
    localparam int BW   = NC * EW;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk;
    logic          rst;
    logic          new_game;
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          move_done;
    logic          move_chg;
    logic [BW-1:0] board;
    logic          win;
    logic          game_over;
    logic [31:0]   score;

    game_core_grid #(
        .GRID_N(N),
        .EXP_W(EW),
        .WIN_EXP(WE),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .new_game(new_game),
        .move_valid(move_valid),
        .move_dir(move_dir),
        .move_ready(move_ready),
        .move_done(move_done),
        .move_chg(move_chg),
        .board(board),
        .win(win),
        .game_over(game_over),
        .score(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          mb [NC];
    longint      m_score;
    bit          m_win;
    bit          m_go;
    logic [15:0] tb_lfsr;

    typedef struct {
        logic       rst_v;
        logic       ng;
        logic       mv;
        logic [1:0] dir;
        logic       exp_ready;
        logic       exp_done;
    } vec_t;

    vec_t vecs [4];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [15:0] lfsr_n(input logic [15:0] l, input int n);
        logic [15:0] v = l;
        for (int i = 0; i < n; i++) v = lfsr_step(v);
        return v;
    endfunction

    // Free-running copy of the random source: seeded on reset/new_game, one step per clock otherwise.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_lfsr <= SEED;
        else if (new_game) tb_lfsr <= SEED;
        else tb_lfsr <= lfsr_step(tb_lfsr);
    end

    function automatic int cell_of(input int d, input int line, input int j);
        case (d)
            0:       return j * N + line;
            1:       return (N - 1 - j) * N + line;
            2:       return line * N + j;
            default: return line * N + (N - 1 - j);
        endcase
    endfunction

    function automatic bit model_move(input int d, output longint gain);
        bit chg = 0;
        gain = 0;
        for (int line = 0; line < N; line++) begin
            int q[$];
            int res[$];
            int k = 0;
            for (int j = 0; j < N; j++) if (mb[cell_of(d, line, j)] != 0) q.push_back(mb[cell_of(d, line, j)]);
            while (k < q.size()) begin
                if (k + 1 < q.size() && q[k] == q[k+1]) begin
                    int m = (q[k] + 1 > MAXE) ? MAXE : q[k] + 1;
                    res.push_back(m);
                    gain += longint'(1) << m;
                    k += 2;
                end else begin
                    res.push_back(q[k]);
                    k += 1;
                end
            end
            for (int j = 0; j < N; j++) begin
                int nv = (j < res.size()) ? res[j] : 0;
                if (nv != mb[cell_of(d, line, j)]) chg = 1;
                mb[cell_of(d, line, j)] = nv;
            end
        end
        return chg;
    endfunction

    // Returns the number of cells examined; l is the LFSR value on the first scan cycle.
    function automatic int model_spawn(input logic [15:0] l);
        logic [15:0] cur = l;
        int start = int'(l[CW-1:0]);
        if (start >= NC) start -= NC;
        for (int i = 0; i < NC; i++) begin
            int p = (start + i) % NC;
            if (mb[p] == 0) begin
                mb[p] = (cur[15:12] == 4'd0) ? 2 : 1;
                return i + 1;
            end
            cur = lfsr_step(cur);
        end
        return NC;
    endfunction

    function automatic void model_flags();
        bit full = 1;
        bit pair = 0;
        for (int i = 0; i < NC; i++) begin
            if (mb[i] >= WE) m_win = 1;
            if (mb[i] == 0) full = 0;
        end
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (c + 1 < N && mb[r*N+c] == mb[r*N+c+1]) pair = 1;
                if (r + 1 < N && mb[r*N+c] == mb[(r+1)*N+c]) pair = 1;
            end
        if (full && !pair) m_go = 1;
    endfunction

    function automatic logic [BW-1:0] pack_board();
        logic [BW-1:0] p = '0;
        for (int i = 0; i < NC; i++) p[i*EW +: EW] = EW'(mb[i]);
        return p;
    endfunction

    function automatic logic [31:0] exp_score();
`ifdef GAME_SCORE_EN
        return m_score[31:0];
`else
        return 32'd0;
`endif
    endfunction

    function automatic void model_init();
        logic [15:0] l = lfsr_step(SEED);
        int s;
        for (int i = 0; i < NC; i++) mb[i] = 0;
        m_score = 0;
        m_win = 0;
        m_go = 0;
        s = model_spawn(l);
        s = model_spawn(lfsr_n(l, s));
        model_flags();
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        rst        = v.rst_v;
        new_game   = v.ng;
        move_valid = v.mv;
        move_dir   = v.dir;
    endtask

    task automatic wait_init();
        int cyc = 0;
        bit saw_done = 0;
        while (!move_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (move_done) saw_done = 1;
        end
        check_output("init_ready", move_ready, 1);
        check_output("init_no_done", saw_done, 0);
        check_output("init_board", board, pack_board());
        check_output("init_score", score, 0);
        check_output("init_win", win, 0);
        check_output("init_game_over", game_over, 0);
    endtask

    task automatic do_move(input int d);
        logic [15:0] l0 = tb_lfsr;
        longint gain;
        bit chg;
        int s = 0;
        int cnt = 0;
        int exp_lat;
        chg = model_move(d, gain);
        if (chg) begin
            s = model_spawn(lfsr_n(l0, N + 1));
            m_score += gain;
            if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
        end
        exp_lat = chg ? N + s + 1 : N + 1;
        model_flags();
        move_valid = 1'b1;
        move_dir   = 2'(d);
        while (cnt < 64) begin
            @(posedge clk);
            cnt++;
            #1 move_valid = 1'b0;
            @(negedge clk);
            if (move_done) break;
        end
        check_output("move_latency", cnt, exp_lat);
        check_output("move_chg", move_chg, chg);
        check_output("move_board", board, pack_board());
        check_output("move_score", score, exp_score());
        @(negedge clk);
        check_output("done_pulse", move_done, 0);
        check_output("win_flag", win, m_win);
        check_output("game_over_flag", game_over, m_go);
        check_output("ready_after", move_ready, !m_go);
    endtask

    task automatic ng_mid_move(input int d);
        bit saw_done = 0;
        move_valid = 1'b1;
        move_dir   = 2'(d);
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(negedge clk);
        new_game = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (move_done) saw_done = 1;
        end
        check_output("abort_no_done", saw_done, 0);
        check_output("abort_board", board, 0);
        check_output("abort_ready", move_ready, 0);
        check_output("abort_score", score, 0);
        new_game = 1'b0;
        model_init();
        wait_init();
    endtask

    task automatic game_over_phase();
        bit saw_done = 0;
        move_valid = 1'b1;
        move_dir   = 2'($urandom_range(0, 3));
        repeat (4) begin
            @(negedge clk);
            if (move_done) saw_done = 1;
        end
        move_valid = 1'b0;
        check_output("over_no_accept", saw_done, 0);
        check_output("over_board_held", board, pack_board());
        check_output("over_ready", move_ready, 0);
        new_game = 1'b1;
        repeat (2) @(negedge clk);
        check_output("newgame_win_clr", win, 0);
        check_output("newgame_over_clr", game_over, 0);
        new_game = 1'b0;
        model_init();
        wait_init();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wins = 0;
        int overs = 0;
        rst        = 1'b1;
        new_game   = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'd0;
        #2 rst = 1'b0;

        vecs[0] = '{rst_v: 1'b0, ng: 1'b0, mv: 1'b1, dir: 2'd2, exp_ready: 1'b0, exp_done: 1'b0};
        vecs[1] = '{rst_v: 1'b0, ng: 1'b1, mv: 1'b1, dir: 2'd0, exp_ready: 1'b0, exp_done: 1'b0};
        vecs[2] = '{rst_v: 1'b1, ng: 1'b1, mv: 1'b1, dir: 2'd3, exp_ready: 1'b0, exp_done: 1'b0};
        vecs[3] = '{rst_v: 1'b1, ng: 1'b1, mv: 1'b0, dir: 2'd1, exp_ready: 1'b0, exp_done: 1'b0};

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output("vec_ready", move_ready, vecs[i].exp_ready);
            check_output("vec_done", move_done, vecs[i].exp_done);
            check_output("vec_board", board, 0);
            check_output("vec_score", score, 0);
            check_output("vec_win", win, 0);
            check_output("vec_game_over", game_over, 0);
        end

        new_game   = 1'b0;
        move_valid = 1'b0;
        model_init();
        wait_init();

        ng_mid_move(2);

        for (int it = 0; it < 400; it++) begin
            if (m_go) begin
                overs++;
                game_over_phase();
            end else if ($urandom_range(0, 29) == 0) begin
                ng_mid_move(int'($urandom_range(0, 3)));
            end else begin
                do_move(int'($urandom_range(0, 3)));
                if (m_win) wins++;
            end
        end
        $display("[TB] moves with win set: %0d, game-over episodes: %0d", wins, overs);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
